// File: rtl/cpu_cmd_sequencer_pkg.sv
// Shared command encodings and types for the CPU command sequencer.
// Optional RAW gap feature is controlled by CPU_CMD_SEQ_HAZARD_EN.
package cpu_cmd_sequencer_pkg;

  localparam int CMD_W = 13;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_SUB   = 2'b11;

  // Packed layout: [12:11]=op, [10:9]=reg, [8:0]=addr
  typedef struct packed {
    logic [1:0] op;
    logic [1:0] rnum;
    logic [8:0] addr;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01
`ifdef CPU_CMD_SEQ_HAZARD_EN
    , ST_GAP = 2'b10
`endif
  } seq_state_e;

  function automatic logic raw_hazard(input logic [1:0] prev_op,
                                      input logic [1:0] prev_reg,
                                      input cmd_t       nxt);
    return (prev_op == OP_LOAD) && (nxt.op == OP_STORE) && (nxt.rnum == prev_reg);
  endfunction

endpackage

// File: rtl/cpu_cmd_sequencer_fifo.sv
// Synchronous FIFO holding pending commands; reports occupancy, full and empty.
module cpu_cmd_sequencer_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             push_s;
  logic             pop_s;

  assign full   = (level_r == LW'(DEPTH));
  assign empty  = (level_r == {LW{1'b0}});
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;
  assign rdata  = mem_r[rd_ptr_r];
  assign level  = level_r;

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= wdata;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/cpu_cmd_sequencer.sv
// Pops queued commands and drives CPU select/regnumber/madd for HOLD_CYC clocks each.
// Define CPU_CMD_SEQ_HAZARD_EN to insert one gap cycle on load->store to the same reg.
module cpu_cmd_sequencer
  import cpu_cmd_sequencer_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter int         HOLD_CYC = 2,
  parameter logic [1:0] IDLE_SEL = 2'b10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [CMD_W-1:0]       cmd_data,
  output logic [1:0]             select,
  output logic [1:0]             regnumber,
  output logic [8:0]             madd,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            issued_count,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int              CNT_W   = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_CYC - 1);

  seq_state_e       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             pop_s;
  logic             fifo_full_s, fifo_empty_s;
  logic [CMD_W-1:0] head_bits_s;
  cmd_t             head_s;
  logic             cnt_zero_s;
  logic [1:0]       select_r, sel_nxt_s;
  logic [1:0]       regnumber_r, reg_nxt_s;
  logic [8:0]       madd_r, madd_nxt_s;
  logic             done_r, done_nxt_s;
  logic [15:0]      issued_count_r;
`ifdef CPU_CMD_SEQ_HAZARD_EN
  logic [1:0]       last_op_r;
  logic             hazard_s;
`endif

  cpu_cmd_sequencer_fifo #(.DEPTH(DEPTH), .WIDTH(CMD_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid && cmd_ready),
    .wdata (cmd_data),
    .pop   (pop_s),
    .rdata (head_bits_s),
    .level (fifo_level),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign head_s       = cmd_t'(head_bits_s);
  assign cnt_zero_s   = (cnt_r == {CNT_W{1'b0}});
  assign cmd_ready    = !fifo_full_s;
  assign busy         = (state_r != ST_IDLE) || !fifo_empty_s;
  assign select       = select_r;
  assign regnumber    = regnumber_r;
  assign madd         = madd_r;
  assign done         = done_r;
  assign issued_count = issued_count_r;
`ifdef CPU_CMD_SEQ_HAZARD_EN
  assign hazard_s     = raw_hazard(last_op_r, regnumber_r, head_s);
`endif

  // State register plus registered CPU-facing outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      cnt_r          <= {CNT_W{1'b0}};
      select_r       <= IDLE_SEL;
      regnumber_r    <= 2'b00;
      madd_r         <= 9'd0;
      done_r         <= 1'b0;
      issued_count_r <= 16'd0;
`ifdef CPU_CMD_SEQ_HAZARD_EN
      last_op_r      <= OP_ADD;
`endif
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      select_r    <= sel_nxt_s;
      regnumber_r <= reg_nxt_s;
      madd_r      <= madd_nxt_s;
      done_r      <= done_nxt_s;
      if ((state_r == ST_ISSUE) && cnt_zero_s) issued_count_r <= issued_count_r + 16'd1;
`ifdef CPU_CMD_SEQ_HAZARD_EN
      if (pop_s) last_op_r <= head_s.op;
`endif
    end
  end

  // Next-state: pop on entry to ISSUE, chain back-to-back when the queue has work
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    pop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_ISSUE;
          cnt_nxt_s   = HOLD_M1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!cnt_zero_s) begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end else if (fifo_empty_s) begin
          state_nxt_s = ST_IDLE;
`ifdef CPU_CMD_SEQ_HAZARD_EN
        end else if (hazard_s) begin
          state_nxt_s = ST_GAP;
`endif
        end else begin
          pop_s       = 1'b1;
          state_nxt_s = ST_ISSUE;
          cnt_nxt_s   = HOLD_M1;
        end
      end
`ifdef CPU_CMD_SEQ_HAZARD_EN
      ST_GAP: begin
        if (!fifo_empty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_ISSUE;
          cnt_nxt_s   = HOLD_M1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
`endif
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Output next-values: load from head on pop, park select when not issuing
  always_comb begin
    sel_nxt_s  = select_r;
    reg_nxt_s  = regnumber_r;
    madd_nxt_s = madd_r;
    if (pop_s) begin
      sel_nxt_s  = head_s.op;
      reg_nxt_s  = head_s.rnum;
      madd_nxt_s = head_s.addr;
    end else if (state_nxt_s != ST_ISSUE) begin
      sel_nxt_s  = IDLE_SEL;
    end else begin
      sel_nxt_s  = select_r;
    end
    done_nxt_s = (state_nxt_s == ST_ISSUE) && (cnt_nxt_s == {CNT_W{1'b0}});
  end

endmodule

// File: tb/tb_cpu_cmd_sequencer.sv
// Directed self-checking bench for cpu_cmd_sequencer (DEPTH=4, HOLD_CYC=2).
module tb_cpu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [12:0] cmd_data = 13'd0;
  logic [1:0]  select;
  logic [1:0]  regnumber;
  logic [8:0]  madd;
  logic        busy;
  logic        done;
  logic [15:0] issued_count;
  logic [2:0]  fifo_level;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic mon_en = 1'b0;
  int          done_cyc[$];
  logic [8:0]  done_madd[$];

`ifdef CPU_CMD_SEQ_HAZARD_EN
  logic gap_en = 1'b1;
`else
  logic gap_en = 1'b0;
`endif

  cpu_cmd_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .select(select), .regnumber(regnumber), .madd(madd),
    .busy(busy), .done(done), .issued_count(issued_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en && done) begin
      done_cyc.push_back(cyc);
      done_madd.push_back(madd);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if ({select, regnumber, madd, busy, cmd_ready, issued_count, done, fifo_level} !==
          {2'b10, 2'b00, 9'd0, 1'b0, 1'b1, 16'd0, 1'b0, 3'd0}) begin
        bad++;
        $display("FAIL reset_idle cyc%0d: sel=%b reg=%0d madd=%0d busy=%b rdy=%b cnt=%0d done=%b lvl=%0d expected sel=10 others idle",
                 i, select, regnumber, madd, busy, cmd_ready, issued_count, done, fifo_level);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = {2'b00, 2'd1, 9'd5};
    @(negedge clk);
    cmd_valid = 1'b0;
    total++;
    if (fifo_level !== 3'd1 || select !== 2'b10) begin
      bad++;
      $display("FAIL single_queued: lvl=%0d sel=%b expected lvl=1 sel=10", fifo_level, select);
    end
    @(negedge clk);
    total++;
    if ({select, regnumber, madd, done} !== {2'b00, 2'd1, 9'd5, 1'b0}) begin
      bad++;
      $display("FAIL single_hold1: sel=%b reg=%0d madd=%0d done=%b expected 00/1/5/0", select, regnumber, madd, done);
    end
    @(negedge clk);
    total++;
    if ({select, regnumber, madd, done} !== {2'b00, 2'd1, 9'd5, 1'b1}) begin
      bad++;
      $display("FAIL single_hold2: sel=%b reg=%0d madd=%0d done=%b expected 00/1/5/1", select, regnumber, madd, done);
    end
    @(negedge clk);
    total++;
    if ({select, regnumber, madd, done, issued_count, busy} !== {2'b10, 2'd1, 9'd5, 1'b0, 16'd1, 1'b0}) begin
      bad++;
      $display("FAIL single_after: sel=%b reg=%0d madd=%0d done=%b cnt=%0d busy=%b expected 10/1/5/0/1/0",
               select, regnumber, madd, done, issued_count, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic saw_full = 1'b0;
    int   guard;
    do_reset();
    done_cyc.delete();
    done_madd.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_data  = {2'b11, i[1:0], 9'(16 + i)};
      guard = 0;
      while (!cmd_ready && guard < 50) begin
        if (fifo_level == 3'd4) saw_full = 1'b1;
        @(negedge clk);
        guard++;
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    guard = 0;
    while (done_cyc.size() < 8 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    total++;
    if (saw_full !== 1'b1) begin
      bad++;
      $display("FAIL b2b_full: ready-low-at-level-4 seen=%b expected 1", saw_full);
    end
    total++;
    if (done_cyc.size() != 8) begin
      bad++;
      $display("FAIL b2b_done_count: got %0d done pulses expected 8", done_cyc.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (done_madd[i] !== 9'(16 + i)) begin
          bad++;
          $display("FAIL b2b_order[%0d]: madd=%0d expected %0d", i, done_madd[i], 16 + i);
        end
        if (i > 0) begin
          total++;
          if (done_cyc[i] - done_cyc[i-1] != 2) begin
            bad++;
            $display("FAIL b2b_spacing[%0d]: gap=%0d cycles expected 2", i, done_cyc[i] - done_cyc[i-1]);
          end
        end
      end
    end
    total++;
    if ({issued_count, select, busy, fifo_level} !== {16'd8, 2'b10, 1'b0, 3'd0}) begin
      bad++;
      $display("FAIL b2b_end: cnt=%0d sel=%b busy=%b lvl=%0d expected 8/10/0/0", issued_count, select, busy, fifo_level);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = {2'b01, 2'd2, 9'd7};
    @(negedge clk);
    cmd_data  = {2'b11, 2'd3, 9'd9};
    @(negedge clk);
    cmd_valid = 1'b0;
    total++;
    if ({select, regnumber, madd, fifo_level} !== {2'b01, 2'd2, 9'd7, 3'd1}) begin
      bad++;
      $display("FAIL rstmid_store: sel=%b reg=%0d madd=%0d lvl=%0d expected 01/2/7/1", select, regnumber, madd, fifo_level);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if ({select, regnumber, madd, done, fifo_level, issued_count, busy, cmd_ready} !==
        {2'b10, 2'd0, 9'd0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL rstmid_async: sel=%b reg=%0d madd=%0d done=%b lvl=%0d cnt=%0d busy=%b rdy=%b expected reset values",
               select, regnumber, madd, done, fifo_level, issued_count, busy, cmd_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({done, issued_count, select, busy} !== {1'b0, 16'd0, 2'b10, 1'b0}) begin
        bad++;
        $display("FAIL rstmid_after%0d: done=%b cnt=%0d sel=%b busy=%b expected 0/0/10/0", i, done, issued_count, select, busy);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    force dut.issued_count_r = 16'hFFFF;
    @(negedge clk);
    release dut.issued_count_r;
    cmd_valid = 1'b1;
    cmd_data  = {2'b10, 2'd0, 9'd3};
    @(negedge clk);
    cmd_valid = 1'b0;
    total++;
    if (issued_count !== 16'hFFFF) begin
      bad++;
      $display("FAIL wrap_preload: cnt=%h expected ffff", issued_count);
    end
    repeat (2) @(negedge clk);
    total++;
    if ({done, issued_count} !== {1'b1, 16'hFFFF}) begin
      bad++;
      $display("FAIL wrap_final_hold: done=%b cnt=%h expected 1/ffff", done, issued_count);
    end
    @(negedge clk);
    total++;
    if (issued_count !== 16'h0000) begin
      bad++;
      $display("FAIL wrap_zero: cnt=%h expected 0000", issued_count);
    end
  endtask

  task automatic test_hazard(input logic [1:0] st_reg, input logic exp_gap);
    do_reset();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = {2'b00, 2'd2, 9'd1};
    @(negedge clk);
    cmd_data  = {2'b01, st_reg, 9'd2};
    @(negedge clk);
    cmd_valid = 1'b0;
    total++;
    if ({select, regnumber, madd} !== {2'b00, 2'd2, 9'd1}) begin
      bad++;
      $display("FAIL haz_load r%0d: sel=%b reg=%0d madd=%0d expected 00/2/1", st_reg, select, regnumber, madd);
    end
    repeat (2) @(negedge clk);
    total++;
    if (exp_gap) begin
      if ({select, regnumber, madd} !== {2'b10, 2'd2, 9'd1}) begin
        bad++;
        $display("FAIL haz_gap r%0d: sel=%b reg=%0d madd=%0d expected 10/2/1", st_reg, select, regnumber, madd);
      end
    end else begin
      if ({select, regnumber, madd} !== {2'b01, st_reg, 9'd2}) begin
        bad++;
        $display("FAIL haz_nogap r%0d: sel=%b reg=%0d madd=%0d expected 01/%0d/2", st_reg, select, regnumber, madd, st_reg);
      end
    end
    @(negedge clk);
    total++;
    if ({select, regnumber, madd} !== {2'b01, st_reg, 9'd2}) begin
      bad++;
      $display("FAIL haz_store r%0d: sel=%b reg=%0d madd=%0d expected 01/%0d/2", st_reg, select, regnumber, madd, st_reg);
    end
    repeat (4) @(negedge clk);
    total++;
    if ({issued_count, select, busy} !== {16'd2, 2'b10, 1'b0}) begin
      bad++;
      $display("FAIL haz_end r%0d: cnt=%0d sel=%b busy=%b expected 2/10/0", st_reg, issued_count, select, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_hazard(2'd2, gap_en);
    test_hazard(2'd3, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
